lsu_unit: RTL and testbench
===========================

# lsu_unit

Load/store unit sitting between the execute stage and data memory, producing the `data_m` load word consumed by the writeback select path. It accepts one memory operation at a time from the pipeline, drives a valid/ready request to data memory, waits for the response, and returns byte/half/word-aligned, sign- or zero-extended load data. It stalls the pipeline while an access is in flight and flags misaligned or illegal accesses without touching memory.

## Interface
- `XLEN`, 32: data/address width; only 32 is supported.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  execute stage presents a memory op (sampled only in IDLE)
- `req_we`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU illegal for stores)
- `req_addr`  in  32  effective byte address (ALU result)
- `req_wdata`  in  32  store data (rs2)
- `busy`  out  1  pipeline stall; high while in REQ or RESP
- `done`  out  1  one-cycle pulse: operation complete
- `err`  out  1  one-cycle pulse: misaligned or illegal funct3, no memory access made
- `data_m`  out  32  extended load result; holds until the next load completes
- `mem_valid`  out  1  memory request valid
- `mem_ready`  in  1  memory accepts request
- `mem_we`  out  1  request is a write
- `mem_be`  out  4  byte enables
- `mem_addr`  out  32  word-aligned address (`req_addr[31:2]`, 2'b00)
- `mem_wdata`  out  32  lane-replicated store data
- `mem_rvalid`  in  1  response: read data valid, or write acknowledged
- `mem_rdata`  in  32  read data

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE, `req_valid`=1, legal and aligned: register op, address offset, `mem_*` fields; go to REQ.
- IDLE, `req_valid`=1, illegal (H with `addr[0]`=1; W with `addr[1:0]`≠0; funct3 011/110/111; BU/HU store): stay IDLE; pulse `err` next cycle; no `done`, `data_m` unchanged.
- REQ: `mem_valid`=1 with stable fields until `mem_ready`=1; then RESP.
- RESP: wait for `mem_rvalid`. On it: for loads, extract the lane at the registered offset and sign-extend (B/H) or zero-extend (BU/HU/W) into `data_m`; pulse `done`; return to IDLE.
- Byte enables: B → `4'b0001 << off`; H → `4'b0011` (off 0) or `4'b1100` (off 2); W → `4'b1111`. Applied to loads as well.
- Store data: B replicates `wdata[7:0]` ×4; H replicates `wdata[15:0]` ×2; W passes through.
- `mem_rvalid` outside RESP is ignored.
- Upstream must drop `req_valid` in the `done` cycle unless issuing a new op; a `req_valid` seen in IDLE is always a new request.

## Timing
- Reset (async assert, sync deassert expected): state IDLE; `busy`, `done`, `err`, `mem_valid`, `mem_we`=0; `mem_be`=0; `mem_addr`, `mem_wdata`, `data_m`=0. Reset mid-access abandons it; any late `mem_rvalid` is ignored.
- All outputs are registered.
- Acceptance at edge N: `busy`, `mem_valid` high from N+1.
- `mem_ready` sampled at edge M: `mem_valid` low from M+1.
- `mem_rvalid` sampled at edge K: `done`, `data_m` updated, and `busy` low from K+1.
- Minimum latency with zero-wait memory (ready at N+1, rvalid at N+2): `done` at N+3.
- `mem_ready` and `mem_rvalid` are never high in the same cycle; the response always follows a separate accept.
- `err` is high in cycle N+1 after an illegal request at edge N; the unit is ready again at N+1.

## Structure
- Package `lsu_pkg`: funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`), state enum `lsu_state_t`.
- Sub-module `lsu_align` (combinational): computes `mem_be` and replicated store data from funct3/offset, and extracts/extends load data. The FSM and registers stay in `lsu_unit`.

## Test plan
- LB from 0x1003, `mem_rdata`=0x80FF_FF00, zero-wait → `mem_addr`=0x1000, `mem_be`=4'b1000, `data_m`=0xFFFF_FF80, `done` at N+3.
- LHU from 0x2002, `mem_rdata`=0x8001_1234 → `mem_be`=4'b1100, `data_m`=0x0000_8001.
- SB to 0x3001, `req_wdata`=0xDEAD_BEA5 → `mem_we`=1, `mem_be`=4'b0010, `mem_wdata`=0xA5A5_A5A5; `mem_ready` delayed 3 cycles → fields held stable, `busy` high throughout.
- LW from 0x4002 → `err` pulse at N+1, `mem_valid` never asserted, `data_m` unchanged, `busy`=0.
- Assert `rst_n`=0 while in RESP, then drive `mem_rvalid`=1 after release → all outputs zero, no `done`, state IDLE.
- Back-to-back SW then LW, with the new `req_valid` in the `done` cycle → second op accepted, `mem_valid` high the next cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = XLEN / 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } lsu_state_t;

    typedef struct packed {
        logic            we;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } mem_req_t;

    // Alignment and funct3 legality; unsigned loads have no store counterpart.
    function automatic logic op_legal(input logic we, input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B:    op_legal = 1'b1;
            F3_H:    op_legal = ~off[0];
            F3_W:    op_legal = (off == 2'b00);
            F3_BU:   op_legal = ~we;
            F3_HU:   op_legal = ~we & ~off[0];
            default: op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: byte enables, store-data replication and load extract/extend.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_off,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata,
    output logic [BE_W-1:0] o_be_c,
    output logic [XLEN-1:0] o_wdata_c,
    output logic [XLEN-1:0] o_rdata_c
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
    assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_be_c    = 4'b1111;
        o_wdata_c = i_wdata;
        o_rdata_c = i_rdata;
        case (i_funct3)
            F3_B, F3_BU: begin
                o_be_c    = 4'b0001 << i_off;
                o_wdata_c = {4{i_wdata[7:0]}};
                o_rdata_c = (i_funct3 == F3_B) ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
            end
            F3_H, F3_HU: begin
                o_be_c    = i_off[1] ? 4'b1100 : 4'b0011;
                o_wdata_c = {2{i_wdata[15:0]}};
                o_rdata_c = (i_funct3 == F3_H) ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_unit.sv
// Load/store unit: one op at a time, valid/ready request to data memory,
// aligned and extended load data, err pulse for illegal/misaligned ops.
module lsu_unit
    import lsu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [XLEN-1:0] data_m,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic            mem_we,
    output logic [BE_W-1:0] mem_be,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    lsu_state_t      r_state;
    mem_req_t        r_req;
    logic            r_mem_valid;
    logic [2:0]      r_f3;
    logic [1:0]      r_off;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic [XLEN-1:0] r_data_m;

    logic [2:0]      w_f3;
    logic [1:0]      w_off;
    logic [BE_W-1:0] w_be;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_load;
    logic            w_legal;

    // Aligner sees the incoming op in IDLE and the captured op afterwards.
    assign w_f3    = (r_state == S_IDLE) ? req_funct3    : r_f3;
    assign w_off   = (r_state == S_IDLE) ? req_addr[1:0] : r_off;
    assign w_legal = op_legal(req_we, req_funct3, req_addr[1:0]);

    lsu_align u_align (
        .i_funct3  (w_f3),
        .i_off     (w_off),
        .i_wdata   (req_wdata),
        .i_rdata   (mem_rdata),
        .o_be_c    (w_be),
        .o_wdata_c (w_wdata),
        .o_rdata_c (w_load)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_req       <= '0;
            r_mem_valid <= 1'b0;
            r_f3        <= 3'd0;
            r_off       <= 2'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_data_m    <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (w_legal) begin
                            r_f3        <= req_funct3;
                            r_off       <= req_addr[1:0];
                            r_req       <= '{we: req_we, be: w_be,
                                             addr: {req_addr[XLEN-1:2], 2'b00},
                                             wdata: w_wdata};
                            r_mem_valid <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= S_REQ;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        r_mem_valid <= 1'b0;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (mem_rvalid) begin
                        if (!r_req.we) r_data_m <= w_load;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign data_m    = r_data_m;
    assign mem_valid = r_mem_valid;
    assign mem_we    = r_req.we;
    assign mem_be    = r_req.be;
    assign mem_addr  = r_req.addr;
    assign mem_wdata = r_req.wdata;

endmodule

// File: tb/tb_lsu_unit.sv
// Randomized self-checking bench for lsu_unit against a size/sign arithmetic model.
module tb_lsu_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] data_m;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int          n_cmp;
    int          n_fail;
    logic [31:0] exp_data_m;

    lsu_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .data_m     (data_m),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: access size in bytes, signedness, lane offset.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [31:0] rd,
                                  output bit lg, output logic [3:0] be,
                                  output logic [31:0] wrep, output logic [31:0] ext);
        int     size;
        bit     sgn;
        int     off;
        longint v;
        off  = int'(addr[1:0]);
        lg   = 1'b1;
        sgn  = 1'b0;
        size = 4;
        case (f3)
            3'd0:    begin size = 1; sgn = 1'b1; end
            3'd1:    begin size = 2; sgn = 1'b1; end
            3'd2:    size = 4;
            3'd4:    size = 1;
            3'd5:    size = 2;
            default: lg = 1'b0;
        endcase
        if (we && f3[2]) lg = 1'b0;
        if ((off % size) != 0) lg = 1'b0;
        be = 4'(((1 << size) - 1) << off);
        for (int i = 0; i < 4; i++) wrep[8*i +: 8] = wd[8*(i % size) +: 8];
        v = (longint'(rd) >> (8 * off)) & ((longint'(1) << (8 * size)) - 1);
        if (sgn && (((v >> (8 * size - 1)) & 1) == 1)) v = v - (longint'(1) << (8 * size));
        ext = 32'(v);
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One operation from request through done; ends in the done cycle.
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int rdy_dly, input int rv_dly, input string tag);
        bit          lg;
        logic [3:0]  be;
        logic [31:0] wrep;
        logic [31:0] ext;
        model(we, f3, addr, wd, rd, lg, be, wrep, ext);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        if (!lg) begin
            n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL %s err: got %b want 1", tag, err); end
            n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy on illegal: got %b want 0", tag, busy); end
            n_cmp++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL %s mem_valid on illegal: got %b want 0", tag, mem_valid); end
            n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL %s done on illegal: got %b want 0", tag, done); end
            n_cmp++; if (data_m !== exp_data_m) begin n_fail++; $display("FAIL %s data_m on illegal: got %h want %h", tag, data_m, exp_data_m); end
            return;
        end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL %s err on legal: got %b want 0", tag, err); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy at accept: got %b want 1", tag, busy); end
        n_cmp++; if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL %s mem_valid at accept: got %b want 1", tag, mem_valid); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL %s done at accept: got %b want 0", tag, done); end
        n_cmp++; if (mem_we !== we) begin n_fail++; $display("FAIL %s mem_we: got %b want %b", tag, mem_we, we); end
        n_cmp++; if (mem_be !== be) begin n_fail++; $display("FAIL %s mem_be: got %b want %b", tag, mem_be, be); end
        n_cmp++; if (mem_addr !== {addr[31:2], 2'b00}) begin n_fail++; $display("FAIL %s mem_addr: got %h want %h", tag, mem_addr, {addr[31:2], 2'b00}); end
        if (we) begin
            n_cmp++; if (mem_wdata !== wrep) begin n_fail++; $display("FAIL %s mem_wdata: got %h want %h", tag, mem_wdata, wrep); end
        end
        repeat (rdy_dly) begin
            @(posedge clk);
            #1;
            n_cmp++; if ({busy, mem_valid} !== 2'b11) begin n_fail++; $display("FAIL %s busy/valid while waiting ready: got %b want 11", tag, {busy, mem_valid}); end
            n_cmp++; if ({mem_we, mem_be, mem_addr} !== {we, be, addr[31:2], 2'b00}) begin n_fail++; $display("FAIL %s fields unstable: got %b/%b/%h", tag, mem_we, mem_be, mem_addr); end
            if (we) begin
                n_cmp++; if (mem_wdata !== wrep) begin n_fail++; $display("FAIL %s mem_wdata unstable: got %h want %h", tag, mem_wdata, wrep); end
            end
        end
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        n_cmp++; if ({busy, mem_valid, done} !== 3'b100) begin n_fail++; $display("FAIL %s after ready busy/valid/done: got %b want 100", tag, {busy, mem_valid, done}); end
        repeat (rv_dly) begin
            @(posedge clk);
            #1;
            n_cmp++; if ({busy, done} !== 2'b10) begin n_fail++; $display("FAIL %s waiting rvalid busy/done: got %b want 10", tag, {busy, done}); end
        end
        mem_rvalid = 1'b1; mem_rdata = rd;
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0; mem_rdata = $urandom;
        if (!we) exp_data_m = ext;
        n_cmp++; if ({busy, done} !== 2'b01) begin n_fail++; $display("FAIL %s completion busy/done: got %b want 01", tag, {busy, done}); end
        n_cmp++; if (data_m !== exp_data_m) begin n_fail++; $display("FAIL %s data_m: got %h want %h", tag, data_m, exp_data_m); end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        exp_data_m = '0;
        #1;
        n_cmp++; if ({busy, done, err, mem_valid, mem_we, mem_be, mem_addr, mem_wdata, data_m} !== '0) begin
            n_fail++; $display("FAIL reset outputs: got b%b d%b e%b v%b we%b be%b a%h wd%h dm%h want all 0",
                               busy, done, err, mem_valid, mem_we, mem_be, mem_addr, mem_wdata, data_m); end
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_load_byte;
        run_op(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FF00, 0, 0, "lb_1003");
        n_cmp++; if (data_m !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_const data_m: got %h want ffffff80", data_m); end
        idle(1);
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL lb done pulse width: got %b want 0", done); end
    endtask

    task automatic test_load_half_u;
        run_op(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_1234, 1, 2, "lhu_2002");
        n_cmp++; if (data_m !== 32'h0000_8001) begin n_fail++; $display("FAIL lhu_const data_m: got %h want 00008001", data_m); end
        idle(1);
    endtask

    task automatic test_store_wait;
        run_op(1'b1, 3'b000, 32'h0000_3001, 32'hDEAD_BEA5, 32'h1234_5678, 3, 1, "sb_3001");
        n_cmp++; if (mem_wdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL sb_const mem_wdata: got %h want a5a5a5a5", mem_wdata); end
        idle(1);
    endtask

    task automatic test_illegal;
        run_op(1'b0, 3'b010, 32'h0000_4002, 32'h0, 32'h0, 0, 0, "lw_misaligned");
        idle(1);
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err pulse width: got %b want 0", err); end
        run_op(1'b1, 3'b100, 32'h0000_5000, 32'h0, 32'h0, 0, 0, "sbu_illegal");
        run_op(1'b0, 3'b011, 32'h0000_5000, 32'h0, 32'h0, 0, 0, "f3_011");
        // legal op issued in the err cycle must be accepted
        run_op(1'b0, 3'b001, 32'h0000_6002, 32'h0, 32'hFACE_0123, 0, 0, "lh_after_err");
        idle(1);
        run_op(1'b0, 3'b101, 32'h0000_6003, 32'h0, 32'h0, 0, 0, "lhu_odd");
        idle(1);
    endtask

    task automatic test_rvalid_ignored;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        idle(1);
        mem_rvalid = 1'b0;
        n_cmp++; if ({busy, done, mem_valid} !== 3'b000) begin n_fail++; $display("FAIL stray rvalid busy/done/valid: got %b want 000", {busy, done, mem_valid}); end
        n_cmp++; if (data_m !== exp_data_m) begin n_fail++; $display("FAIL stray rvalid data_m: got %h want %h", data_m, exp_data_m); end
    endtask

    task automatic test_reset_mid;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_7000;
        idle(1);
        req_valid = 1'b0;
        mem_ready = 1'b1;
        idle(1);
        mem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({busy, done, err, mem_valid, mem_we, mem_be, mem_addr, mem_wdata, data_m} !== '0) begin
            n_fail++; $display("FAIL mid reset outputs: got b%b v%b be%b a%h dm%h want all 0", busy, mem_valid, mem_be, mem_addr, data_m); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_data_m = '0;
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        idle(1);
        mem_rvalid = 1'b0;
        n_cmp++; if ({busy, done, mem_valid} !== 3'b000) begin n_fail++; $display("FAIL late rvalid busy/done/valid: got %b want 000", {busy, done, mem_valid}); end
        n_cmp++; if (data_m !== 32'h0) begin n_fail++; $display("FAIL late rvalid data_m: got %h want 0", data_m); end
        run_op(1'b0, 3'b100, 32'h0000_7001, 32'h0, 32'h0000_9A00, 0, 0, "lbu_after_reset");
        idle(1);
    endtask

    task automatic test_back_to_back;
        run_op(1'b1, 3'b010, 32'h0000_8000, 32'h1122_3344, 32'h0, 0, 0, "b2b_sw");
        run_op(1'b0, 3'b010, 32'h0000_8000, 32'h0, 32'h5566_7788, 0, 1, "b2b_lw");
        run_op(1'b0, 3'b000, 32'h0000_8002, 32'h0, 32'h0012_0000, 2, 0, "b2b_lb");
        idle(1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 80; i++) begin
            run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), "rand");
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(1);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset;
        test_load_byte;
        test_load_half_u;
        test_store_wait;
        test_illegal;
        test_rvalid_ignored;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
